// File: rtl/ai_move_engine.sv
// Tic-tac-toe computer-opponent move search: win, then block, then preferred free cell.
// Latency: 1..8 edges (win), 9..16 (block), 17 (pick / no_move) after the start edge.
// Backpressure: result held in DONE until ack (ignored on the edge DONE is entered); abort cancels.
//
// Ports:
//   clk, reset (async, active-low)
//   start   - move request, sampled in IDLE only (not queued while busy)
//   abort   - cancel search or presented move, highest priority
//   ack     - consumer took the move, sampled in DONE only
//   pos1..9 - live board cells (00 empty, 01 player, 10 computer, 11 invalid)
//   move    - one-hot chosen cell (bit 0 = pos1), zero unless move_valid
//   move_valid, no_move (one-cycle pulse, board full), busy (state != IDLE)
module ai_move_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       ack,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic [8:0] move,
    output logic       move_valid,
    output logic       no_move,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SCAN_WIN   = 3'd1,
        SCAN_BLOCK = 3'd2,
        PICK       = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;

    state_t          state, next_state;
    logic [2:0]      cnt, next_cnt;
    logic [8:0][1:0] snap;
    logic            snap_load;
    logic [8:0]      next_move;
    logic            next_no_move;

    // Line decode: cell indices (0-based) of the line selected by cnt.
    logic [3:0] idx_a, idx_b, idx_c;
    always_comb begin
        idx_a = 4'd0;
        idx_b = 4'd1;
        idx_c = 4'd2;
        case (cnt)
            3'd0: begin idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2; end
            3'd1: begin idx_a = 4'd3; idx_b = 4'd4; idx_c = 4'd5; end
            3'd2: begin idx_a = 4'd6; idx_b = 4'd7; idx_c = 4'd8; end
            3'd3: begin idx_a = 4'd0; idx_b = 4'd3; idx_c = 4'd6; end
            3'd4: begin idx_a = 4'd1; idx_b = 4'd4; idx_c = 4'd7; end
            3'd5: begin idx_a = 4'd2; idx_b = 4'd5; idx_c = 4'd8; end
            3'd6: begin idx_a = 4'd0; idx_b = 4'd4; idx_c = 4'd8; end
            default: begin idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6; end
        endcase
    end

    // Hit: two cells equal the target owner and the third is empty.
    // Invalid (11) cells match neither target nor empty, so never hit.
    logic [1:0] tgt, cell_a, cell_b, cell_c;
    logic       hit_a, hit_b, hit_c, line_hit;
    logic [8:0] hit_cell;
    always_comb begin
        tgt      = (state == SCAN_BLOCK) ? CELL_PLAYER : CELL_COMP;
        cell_a   = snap[idx_a];
        cell_b   = snap[idx_b];
        cell_c   = snap[idx_c];
        hit_a    = (cell_a == CELL_EMPTY) && (cell_b == tgt) && (cell_c == tgt);
        hit_b    = (cell_b == CELL_EMPTY) && (cell_a == tgt) && (cell_c == tgt);
        hit_c    = (cell_c == CELL_EMPTY) && (cell_a == tgt) && (cell_b == tgt);
        line_hit = hit_a || hit_b || hit_c;
        if (hit_a)
            hit_cell = 9'd1 << idx_a;
        else if (hit_b)
            hit_cell = 9'd1 << idx_b;
        else
            hit_cell = 9'd1 << idx_c;
    end

    // Fallback preference: centre, corners, then edges.
    localparam logic [3:0] PREF [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8,
                                        4'd1, 4'd3, 4'd5, 4'd7};
    logic [8:0] pick_cell;
    logic       pick_found;
    always_comb begin
        pick_cell  = 9'd0;
        pick_found = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!pick_found && snap[PREF[i]] == CELL_EMPTY) begin
                pick_found = 1'b1;
                pick_cell  = 9'd1 << PREF[i];
            end
        end
    end

    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        next_move    = move;
        next_no_move = 1'b0;
        snap_load    = 1'b0;
        case (state)
            IDLE: begin
                next_move = 9'd0;
                if (start) begin
                    snap_load  = 1'b1;
                    next_cnt   = 3'd0;
                    next_state = SCAN_WIN;
                end
            end
            SCAN_WIN, SCAN_BLOCK: begin
                if (abort) begin
                    next_state = IDLE;
                    next_move  = 9'd0;
                end else if (line_hit) begin
                    next_move  = hit_cell;
                    next_state = DONE;
                end else if (cnt == 3'd7) begin
                    next_cnt   = 3'd0;
                    next_state = (state == SCAN_WIN) ? SCAN_BLOCK : PICK;
                end else begin
                    next_cnt = cnt + 3'd1;
                end
            end
            PICK: begin
                if (abort) begin
                    next_state = IDLE;
                    next_move  = 9'd0;
                end else if (pick_found) begin
                    next_move  = pick_cell;
                    next_state = DONE;
                end else begin
                    next_no_move = 1'b1;
                    next_move    = 9'd0;
                    next_state   = IDLE;
                end
            end
            DONE: begin
                if (abort || ack) begin
                    next_move  = 9'd0;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_move  = 9'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            snap    <= '0;
            move    <= 9'd0;
            no_move <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            move    <= next_move;
            no_move <= next_no_move;
            if (snap_load)
                snap <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
        end
    end

    assign move_valid = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ai_move_engine.sv
// Directed bench for ai_move_engine: win/block/pick searches, latency,
// handshake, abort and asynchronous reset, with hand-computed expectations.
module tb_ai_move_engine;

    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] C = 2'b10;

    logic        clk = 1'b0;
    logic        reset, start, abort, ack;
    logic [17:0] board;
    logic [8:0]  move;
    logic        move_valid, no_move, busy;
    logic        perturb;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ai_move_engine dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .pos1(board[1:0]),   .pos2(board[3:2]),   .pos3(board[5:4]),
        .pos4(board[7:6]),   .pos5(board[9:8]),   .pos6(board[11:10]),
        .pos7(board[13:12]), .pos8(board[15:14]), .pos9(board[17:16]),
        .move(move), .move_valid(move_valid), .no_move(no_move), .busy(busy)
    );

    function automatic logic [17:0] brd(input logic [1:0] a1, a2, a3, a4, a5,
                                        a6, a7, a8, a9);
        return {a9, a8, a7, a6, a5, a4, a3, a2, a1};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present board and start so the start edge is E0; returns #1 after E0.
    task automatic launch(input logic [17:0] b);
        @(negedge clk);
        board = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_E0", busy, 1);
    endtask

    // Count edges after E0 until a move or no_move appears (bounded).
    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (perturb) begin
                board = ~board;
                start = ~start;
            end
            @(posedge clk);
            #1 n++;
        end while (!(move_valid || no_move) && n < 40);
        start = 1'b0;
    endtask

    task automatic take_move();
        @(negedge clk) ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        check("ack_move_cleared", move, 0);
        check("ack_valid_cleared", move_valid, 0);
        check("ack_busy_low", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  stable;
        bit  seen;
        reset = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
        board = '0; perturb = 1'b0;

        #12;
        check("rst_move", move, 0);
        check("rst_valid", move_valid, 0);
        check("rst_no_move", no_move, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) reset = 1'b1;

        // Win on line 0 -> pos3, then hold 10 cycles with start pulses.
        launch(brd(C, C, E, E, E, E, E, E, E));
        wait_result(n);
        check("win_latency", n, 1);
        check("win_move", move, 9'h004);
        check("win_valid", move_valid, 1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) start = (i % 2 == 0);
            @(posedge clk);
            #1 if (move !== 9'h004 || move_valid !== 1'b1) stable = 1'b0;
        end
        start = 1'b0;
        check("hold_stable", stable, 1);
        take_move();

        // Win on line 2 beats block on line 1.
        launch(brd(E, E, E, P, P, E, C, C, E));
        wait_result(n);
        check("wbb_latency", n, 3);
        check("wbb_move", move, 9'h100);
        take_move();

        // Block on line 6 with board and start disturbed during the search.
        perturb = 1'b1;
        launch(brd(P, C, E, E, P, E, E, E, E));
        wait_result(n);
        perturb = 1'b0;
        check("blk_latency", n, 15);
        check("blk_move", move, 9'h100);
        take_move();

        // Preference: empty board -> centre.
        launch(brd(E, E, E, E, E, E, E, E, E));
        wait_result(n);
        check("pick_empty_latency", n, 17);
        check("pick_empty_move", move, 9'h010);
        take_move();

        // Preference: centre taken -> pos1.
        launch(brd(E, E, E, E, P, E, E, E, E));
        wait_result(n);
        check("pick_p5_latency", n, 17);
        check("pick_p5_move", move, 9'h001);
        take_move();

        // Full drawn board -> no_move pulse.
        launch(brd(P, C, P, P, C, C, C, P, P));
        wait_result(n);
        check("full_latency", n, 17);
        check("full_no_move", no_move, 1);
        check("full_valid", move_valid, 0);
        check("full_move", move, 0);
        @(posedge clk);
        #1;
        check("full_pulse_end", no_move, 0);
        check("full_busy", busy, 0);

        // ack at the edge move_valid rises is not honoured.
        launch(brd(C, C, E, E, E, E, E, E, E));
        ack = 1'b1;
        @(posedge clk);
        #1 check("early_ack_valid", move_valid, 1);
        check("early_ack_move", move, 9'h004);
        @(posedge clk);
        #1 ack = 1'b0;
        check("late_ack_valid", move_valid, 0);

        // Abort after E5, sampled at E6.
        launch(brd(E, E, E, E, E, E, E, E, E));
        repeat (5) @(posedge clk);
        #1 check("abort_busy_pre", busy, 1);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 if (move_valid || no_move || move != 9'd0) seen = 1'b1;
        end
        check("abort_quiet", seen, 0);

        // Abort in DONE.
        launch(brd(C, C, E, E, E, E, E, E, E));
        wait_result(n);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_done_valid", move_valid, 0);
        check("abort_done_move", move, 0);
        check("abort_done_no_move", no_move, 0);

        // Asynchronous reset mid-SCAN_BLOCK.
        launch(brd(E, E, E, E, E, E, E, E, E));
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("rst_scan_busy", busy, 0);
        @(negedge clk) reset = 1'b1;

        // Asynchronous reset in DONE.
        launch(brd(C, C, E, E, E, E, E, E, E));
        wait_result(n);
        #3 reset = 1'b0;
        #1 check("rst_done_valid", move_valid, 0);
        check("rst_done_move", move, 0);
        @(negedge clk) reset = 1'b1;

        // Engine usable again after reset.
        launch(brd(E, C, E, E, C, E, E, E, E));
        wait_result(n);
        check("post_rst_latency", n, 5);
        check("post_rst_move", move, 9'h080);
        take_move();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
